// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus bundle for axi_burst_master.
// Holds AW, W, B, AR and R channels; master drives requests, slave responds.
interface axi_burst_master_if #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ID_WIDTH  = 1
);
  // AW channel
  logic [G_ID_WIDTH-1:0]  m_axi_awid;
  logic [31:0]            m_axi_awaddr;
  logic [7:0]             m_axi_awlen;
  logic [2:0]             m_axi_awsize;
  logic [1:0]             m_axi_awburst;
  logic                   m_axi_awvalid;
  logic                   m_axi_awready;
  // W channel
  logic [G_DATAWIDTH-1:0] m_axi_wdata;
  logic [3:0]             m_axi_wstrb;
  logic                   m_axi_wlast;
  logic                   m_axi_wvalid;
  logic                   m_axi_wready;
  // B channel
  logic [G_ID_WIDTH-1:0]  m_axi_bid;
  logic [1:0]             m_axi_bresp;
  logic                   m_axi_bvalid;
  logic                   m_axi_bready;
  // AR channel
  logic [G_ID_WIDTH-1:0]  m_axi_arid;
  logic [31:0]            m_axi_araddr;
  logic [7:0]             m_axi_arlen;
  logic [2:0]             m_axi_arsize;
  logic [1:0]             m_axi_arburst;
  logic                   m_axi_arvalid;
  logic                   m_axi_arready;
  // R channel
  logic [G_ID_WIDTH-1:0]  m_axi_rid;
  logic [G_DATAWIDTH-1:0] m_axi_rdata;
  logic [1:0]             m_axi_rresp;
  logic                   m_axi_rlast;
  logic                   m_axi_rvalid;
  logic                   m_axi_rready;

  modport master (
    output m_axi_awid,
    output m_axi_awaddr,
    output m_axi_awlen,
    output m_axi_awsize,
    output m_axi_awburst,
    output m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata,
    output m_axi_wstrb,
    output m_axi_wlast,
    output m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid,
    input  m_axi_bresp,
    input  m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid,
    output m_axi_araddr,
    output m_axi_arlen,
    output m_axi_arsize,
    output m_axi_arburst,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid,
    input  m_axi_rdata,
    input  m_axi_rresp,
    input  m_axi_rlast,
    input  m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awid,
    input  m_axi_awaddr,
    input  m_axi_awlen,
    input  m_axi_awsize,
    input  m_axi_awburst,
    input  m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata,
    input  m_axi_wstrb,
    input  m_axi_wlast,
    input  m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid,
    output m_axi_bresp,
    output m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid,
    input  m_axi_araddr,
    input  m_axi_arlen,
    input  m_axi_arsize,
    input  m_axi_arburst,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid,
    output m_axi_rdata,
    output m_axi_rresp,
    output m_axi_rlast,
    output m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-command AXI4 INCR burst master: one write or read burst per command.
// Ports: s_aclk/s_aresetn (async active-low), cmd_* command handshake,
//   wr_* write stream in, rd_* read stream out, done_valid/done_err
//   completion pulse, m_axi AXI4 master bus (interface, master modport).
// Option: AXI_MASTER_STATS_EN adds stat_wr_cnt/stat_rd_cnt done counters.
module axi_burst_master #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ID_WIDTH  = 1,
  parameter int G_ID_VALUE  = 0
) (
  input  logic                   s_aclk,
  input  logic                   s_aresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [G_DATAWIDTH-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [G_DATAWIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  input  logic                   rd_ready,
  output logic                   done_valid,
  output logic                   done_err,
`ifdef AXI_MASTER_STATS_EN
  output logic [15:0]            stat_wr_cnt,
  output logic [15:0]            stat_rd_cnt,
`endif
  axi_burst_master_if.master     m_axi
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA
  } state_t;

  state_t      state;
  logic        cmd_ready_q;
  logic        awvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        done_valid_q;
  logic        done_err_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic in_wdata;
  logic in_rdata;
  logic cmd_fire;
  logic w_fire;
  logic r_fire;
  logic wr_fin;
  logic rd_fin;
  logic r_bad;

  assign in_wdata = (state == WDATA);
  assign in_rdata = (state == RDATA);

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign w_fire   = in_wdata & wr_valid
                  & m_axi.m_axi_wready;
  assign r_fire   = in_rdata & m_axi.m_axi_rvalid
                  & rd_ready;
  assign r_bad    = (m_axi.m_axi_rresp != 2'b00);

  assign wr_fin = (state == WRESP)
                & m_axi.m_axi_bvalid;
  assign rd_fin = r_fire & m_axi.m_axi_rlast;

  // IDs are never checked on the way back in.
  logic unused_ids;
  assign unused_ids = ^{m_axi.m_axi_bid,
                        m_axi.m_axi_rid};

  // Request channels: all fields registered.
  assign m_axi.m_axi_awid    = G_ID_WIDTH'(G_ID_VALUE);
  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awlen   = len_q;
  assign m_axi.m_axi_awsize  = 3'b010;
  assign m_axi.m_axi_awburst = 2'b01;
  assign m_axi.m_axi_awvalid = awvalid_q;

  assign m_axi.m_axi_arid    = G_ID_WIDTH'(G_ID_VALUE);
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arlen   = len_q;
  assign m_axi.m_axi_arsize  = 3'b010;
  assign m_axi.m_axi_arburst = 2'b01;
  assign m_axi.m_axi_arvalid = arvalid_q;

  // Write data is a combinational pass-through,
  // opened only while in WDATA.
  assign m_axi.m_axi_wdata  = wr_data;
  assign m_axi.m_axi_wstrb  = 4'hF;
  assign m_axi.m_axi_wvalid = in_wdata & wr_valid;
  assign m_axi.m_axi_wlast  = in_wdata
                            & (cnt_q == 8'd0);
  assign wr_ready = in_wdata & m_axi.m_axi_wready;

  assign m_axi.m_axi_bready = bready_q;

  // Read data is a combinational pass-through,
  // opened only while in RDATA.
  assign rd_data  = m_axi.m_axi_rdata;
  assign rd_valid = in_rdata & m_axi.m_axi_rvalid;
  assign rd_last  = in_rdata & m_axi.m_axi_rlast;
  assign m_axi.m_axi_rready = in_rdata & rd_ready;

  assign cmd_ready  = cmd_ready_q;
  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state        <= IDLE;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      addr_q       <= 32'd0;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          // Also raises cmd_ready on the first
          // edge after reset release.
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            err_q       <= 1'b0;
            if (cmd_write) begin
              state     <= WADDR;
              awvalid_q <= 1'b1;
            end else begin
              state     <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (m_axi.m_axi_awready) begin
            awvalid_q <= 1'b0;
            cnt_q     <= len_q;
            state     <= WDATA;
          end
        end
        WDATA: begin
          if (w_fire) begin
            if (cnt_q == 8'd0) begin
              bready_q <= 1'b1;
              state    <= WRESP;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        WRESP: begin
          if (m_axi.m_axi_bvalid) begin
            bready_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_valid_q <= 1'b1;
            done_err_q   <= (m_axi.m_axi_bresp
                             != 2'b00);
            state        <= IDLE;
          end
        end
        RADDR: begin
          if (m_axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (r_fire) begin
            if (r_bad) begin
              err_q <= 1'b1;
            end
            // rlast ends the burst; beat count
            // is deliberately not cross-checked.
            if (m_axi.m_axi_rlast) begin
              cmd_ready_q  <= 1'b1;
              done_valid_q <= 1'b1;
              done_err_q   <= err_q | r_bad;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AXI_MASTER_STATS_EN
  // Counters step on the same edge that
  // raises done_valid; they wrap naturally.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      stat_wr_cnt <= 16'd0;
      stat_rd_cnt <= 16'd0;
    end else begin
      if (wr_fin) begin
        stat_wr_cnt <= stat_wr_cnt + 16'd1;
      end
      if (rd_fin) begin
        stat_rd_cnt <= stat_rd_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_fin;
  assign unused_fin = wr_fin ^ rd_fin;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master.
// Directed commands push expectations; negedge monitors pop and compare.
module tb_axi_burst_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        rd_ready = 1'b0;
  logic        done_valid;
  logic        done_err;
`ifdef AXI_MASTER_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;
`endif

  axi_burst_master_if #(
    .G_DATAWIDTH(32),
    .G_ID_WIDTH(1)
  ) bus ();

  axi_burst_master #(
    .G_DATAWIDTH(32),
    .G_ID_WIDTH(1),
    .G_ID_VALUE(0)
  ) dut (
    .s_aclk(clk),
    .s_aresetn(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_last(rd_last),
    .rd_ready(rd_ready),
    .done_valid(done_valid),
    .done_err(done_err),
`ifdef AXI_MASTER_STATS_EN
    .stat_wr_cnt(stat_wr_cnt),
    .stat_rd_cnt(stat_rd_cnt),
`endif
    .m_axi(bus)
  );

  initial begin
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bid     = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid     = 1'b0;
    bus.m_axi_rdata   = 32'd0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
  end

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } a_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } b_t;

  a_t   exp_aw[$];
  a_t   exp_ar[$];
  b_t   exp_w[$];
  b_t   exp_rd[$];
  logic exp_done[$];

  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h",
               name, act, exp);
    end
  endtask

  task automatic bad(input string name,
                     input string why);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Monitors: sample at negedge, where the
  // handshakes about to fire are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        if (exp_aw.size() == 0)
          bad("aw", "got unexpected AW, want none");
        else begin
          chk("awaddr", bus.m_axi_awaddr, exp_aw[0].addr);
          chk("awlen", 32'(bus.m_axi_awlen),
              32'(exp_aw[0].len));
          chk("awsize", 32'(bus.m_axi_awsize), 32'd2);
          chk("awburst", 32'(bus.m_axi_awburst), 32'd1);
          void'(exp_aw.pop_front());
        end
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        if (exp_w.size() == 0)
          bad("w", "got unexpected W beat, want none");
        else begin
          chk("wdata", bus.m_axi_wdata, exp_w[0].data);
          chk("wlast", 32'(bus.m_axi_wlast),
              32'(exp_w[0].last));
          chk("wstrb", 32'(bus.m_axi_wstrb), 32'hF);
          void'(exp_w.pop_front());
        end
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        if (exp_ar.size() == 0)
          bad("ar", "got unexpected AR, want none");
        else begin
          chk("araddr", bus.m_axi_araddr, exp_ar[0].addr);
          chk("arlen", 32'(bus.m_axi_arlen),
              32'(exp_ar[0].len));
          chk("arsize", 32'(bus.m_axi_arsize), 32'd2);
          chk("arburst", 32'(bus.m_axi_arburst), 32'd1);
          void'(exp_ar.pop_front());
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0)
          bad("rd", "got unexpected rd beat, want none");
        else begin
          chk("rd_data", rd_data, exp_rd[0].data);
          chk("rd_last", 32'(rd_last),
              32'(exp_rd[0].last));
          void'(exp_rd.pop_front());
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0)
          bad("done", "got unexpected done, want none");
        else begin
          chk("done_err", 32'(done_err),
              32'(exp_done[0]));
          chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
          void'(exp_done.pop_front());
        end
      end else begin
        chk("done_err_idle", 32'(done_err), 32'd0);
      end
    end
  end

  task automatic issue_cmd(input logic wr,
                           input logic [31:0] addr,
                           input logic [7:0] len);
    bit fire = 1'b0;
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!fire && t < 50) begin
      @(negedge clk);
      fire = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (!fire) bad("cmd", "no cmd_ready within 50 cycles");
  endtask

  task automatic aw_slave(input logic [31:0] addr,
                          input int delay);
    int t = 0;
    while (!bus.m_axi_awvalid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.m_axi_awvalid) begin
      bad("aw_wait", "no awvalid within 50 cycles");
      return;
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("aw_hold_valid", 32'(bus.m_axi_awvalid), 32'd1);
      chk("aw_hold_addr", bus.m_axi_awaddr, addr);
      @(posedge clk);
      #1;
    end
    bus.m_axi_awready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_axi_awready = 1'b0;
  endtask

  task automatic w_source(input logic [31:0] d0,
                          input int n,
                          input bit toggle);
    int k = 0;
    int t = 0;
    bit fire;
    while (k < n && t < 200) begin
      wr_valid = toggle ? (t % 2 == 0) : 1'b1;
      wr_data  = d0 + 32'(k);
      @(negedge clk);
      fire = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      t++;
      if (fire) k++;
    end
    wr_valid = 1'b0;
    if (k < n) bad("w_source", "write beats not accepted");
  endtask

  task automatic w_sink(input logic [31:0] addr,
                        input int n,
                        input logic [1:0] bresp);
    int k = 0;
    int t = 0;
    bus.m_axi_wready = 1'b1;
    while (k < n && t < 200) begin
      @(negedge clk);
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        mem[addr + 32'(4 * k)] = bus.m_axi_wdata;
        k++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.m_axi_wready = 1'b0;
    t = 0;
    while (!bus.m_axi_bready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.m_axi_bready) begin
      bad("bready", "no bready within 50 cycles");
      return;
    end
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = bresp;
    @(posedge clk);
    #1;
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'b00;
  endtask

  task automatic ar_slave();
    int t = 0;
    while (!bus.m_axi_arvalid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.m_axi_arvalid) begin
      bad("ar_wait", "no arvalid within 50 cycles");
      return;
    end
    bus.m_axi_arready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_axi_arready = 1'b0;
  endtask

  task automatic r_slave(input logic [31:0] addr,
                         input int n,
                         input int err_beat);
    int k = 0;
    int t = 0;
    bit fire;
    while (!bus.m_axi_arvalid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    while (bus.m_axi_arvalid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    t = 0;
    while (k < n && t < 200) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = mem[addr + 32'(4 * k)];
      bus.m_axi_rlast  = (k == n - 1);
      bus.m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      @(negedge clk);
      fire = bus.m_axi_rvalid && bus.m_axi_rready;
      @(posedge clk);
      #1;
      t++;
      if (fire) k++;
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rresp  = 2'b00;
    if (k < n) bad("r_slave", "read beats not taken");
  endtask

  task automatic rd_sink(input int n,
                         input int stall_at);
    int k = 0;
    int t = 0;
    int st = 0;
    bit fire;
    while (k < n && t < 200) begin
      if (k == stall_at && st < 3) begin
        rd_ready = 1'b0;
        st++;
      end else begin
        rd_ready = 1'b1;
      end
      @(negedge clk);
      fire = rd_valid && rd_ready;
      @(posedge clk);
      #1;
      t++;
      if (fire) k++;
    end
    rd_ready = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = done_valid;
      if (!seen) @(posedge clk);
    end
    if (!seen) begin
      bad("done_wait", "no done_valid within 50 cycles");
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_pulse_width", 32'(done_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [7:0] len,
                          input logic [31:0] d0,
                          input int aw_delay,
                          input logic [1:0] bresp,
                          input bit toggle);
    int n = int'(len) + 1;
    a_t a;
    b_t b;
    a.addr = addr;
    a.len  = len;
    exp_aw.push_back(a);
    for (int i = 0; i < n; i++) begin
      b.data = d0 + 32'(i);
      b.last = (i == n - 1);
      exp_w.push_back(b);
    end
    exp_done.push_back(bresp != 2'b00);
    fork
      issue_cmd(1'b1, addr, len);
      aw_slave(addr, aw_delay);
      w_source(d0, n, toggle);
      w_sink(addr, n, bresp);
    join
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input logic [7:0] len,
                         input logic [31:0] d0,
                         input int err_beat,
                         input int stall_at);
    int n = int'(len) + 1;
    a_t a;
    b_t b;
    a.addr = addr;
    a.len  = len;
    exp_ar.push_back(a);
    for (int i = 0; i < n; i++) begin
      b.data = d0 + 32'(i);
      b.last = (i == n - 1);
      exp_rd.push_back(b);
    end
    exp_done.push_back(err_beat >= 0);
    fork
      issue_cmd(1'b0, addr, len);
      ar_slave();
      r_slave(addr, n, err_beat);
      rd_sink(n, stall_at);
    join
    wait_done();
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_awvalid"}, 32'(bus.m_axi_awvalid), 32'd0);
    chk({tag, "_arvalid"}, 32'(bus.m_axi_arvalid), 32'd0);
    chk({tag, "_wvalid"}, 32'(bus.m_axi_wvalid), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_bready"}, 32'(bus.m_axi_bready), 32'd0);
    chk({tag, "_rready"}, 32'(bus.m_axi_rready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_done"}, 32'(done_valid), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic abort_write();
    int k = 0;
    int t = 0;
    bit fire;
    bus.m_axi_wready = 1'b1;
    while (k < 2 && t < 100) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC0 + 32'(k);
      @(negedge clk);
      fire = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      t++;
      if (fire) k++;
    end
    wr_data = 32'hC2;
    if (k < 2) bad("abort_w", "first two beats not taken");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    a_t a;
    b_t b;
    #1;
    check_all_low("rst");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_pre_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_post_rst", 32'(cmd_ready), 32'd1);

    do_write(32'h100, 8'd3, 32'hA0, 0, 2'b00, 1'b0);
    do_read(32'h100, 8'd3, 32'hA0, -1, -1);

    do_write(32'h200, 8'd0, 32'h55, 5, 2'b00, 1'b0);
    do_read(32'h200, 8'd0, 32'h55, -1, -1);

    do_write(32'h300, 8'd3, 32'hB0, 0, 2'b00, 1'b1);
    do_read(32'h300, 8'd3, 32'hB0, -1, 2);

    do_write(32'h500, 8'd1, 32'hD0, 0, 2'b10, 1'b0);
    do_read(32'h100, 8'd2, 32'hA0, 1, -1);
    do_read(32'h100, 8'd0, 32'hA0, -1, -1);

    // Abandon a write while beat 2 is pending.
    a.addr = 32'h400;
    a.len  = 8'd3;
    exp_aw.push_back(a);
    b.data = 32'hC0;
    b.last = 1'b0;
    exp_w.push_back(b);
    b.data = 32'hC1;
    exp_w.push_back(b);
    fork
      issue_cmd(1'b1, 32'h400, 8'd3);
      aw_slave(32'h400, 0);
      abort_write();
    join
    chk("pre_rst_wvalid", 32'(bus.m_axi_wvalid), 32'd1);
    chk("pre_rst_wlast", 32'(bus.m_axi_wlast), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("mid_rst");
    wr_valid = 1'b0;
    bus.m_axi_wready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_pre_edge2", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_post_rst2", 32'(cmd_ready), 32'd1);

    do_write(32'h600, 8'd0, 32'hE0, 0, 2'b00, 1'b0);
    do_read(32'h600, 8'd0, 32'hE0, -1, -1);

    chk("left_aw", 32'(exp_aw.size()), 32'd0);
    chk("left_w", 32'(exp_w.size()), 32'd0);
    chk("left_ar", 32'(exp_ar.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_done", 32'(exp_done.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
